// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: outcome decode, redirect/flush sequencing,
// mispredict statistics and the 2-bit branch history table read by fetch.
module branch_resolve #(
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic        ex_pred_taken,
  input  logic        br_eq,
  input  logic        br_l,
  output logic        br_un,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [15:0] mispredict_count
);

  localparam int IDX = $clog2(BHT_ENTRIES);
  localparam int CW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state_q;
  logic [CW-1:0] flush_cnt_q;
  logic          redirect_q;
  logic          flush_q;
  logic [31:0]   redirect_pc_q;
  logic [15:0]   mispredict_count_q;
  logic [1:0]    bht_q [BHT_ENTRIES];

  logic          taken_d;
  logic          legal_d;
  logic [31:0]   br_target;
  logic [31:0]   jalr_sum;
  logic [31:0]   fall_through;
  logic          accept;
  logic          cond_branch;
  logic          mispredict_d;
  logic          redirect_d;
  logic [31:0]   redirect_pc_d;
  logic          bht_we;
  logic [IDX-1:0] upd_idx;
  logic [1:0]    bht_cur;
  logic [1:0]    bht_d;
  logic          unused_ok;

  assign br_un = ex_funct3[1];

  always_comb begin
    taken_d = 1'b0;
    legal_d = 1'b1;
    case (ex_funct3)
      3'b000:         taken_d = br_eq;
      3'b001:         taken_d = !br_eq;
      3'b100, 3'b110: taken_d = br_l;
      3'b101, 3'b111: taken_d = !br_l;
      default:        legal_d = 1'b0;
    endcase
  end

  assign br_target    = ex_pc + ex_imm;
  assign jalr_sum     = ex_rs1 + ex_imm;
  assign fall_through = ex_pc + 32'd4;

  // Jumps take priority over the branch flag, so a branch is only "conditional"
  // when neither jump type is asserted alongside it.
  assign accept       = ex_valid && (state_q == IDLE) && (ex_is_branch || ex_is_jal || ex_is_jalr);
  assign cond_branch  = ex_is_branch && !ex_is_jal && !ex_is_jalr && legal_d;
  assign mispredict_d = accept && cond_branch && (taken_d != ex_pred_taken);
  assign redirect_d   = accept && (ex_is_jal || ex_is_jalr || mispredict_d);

  always_comb begin
    redirect_pc_d = fall_through;
    if (ex_is_jalr)     redirect_pc_d = {jalr_sum[31:1], 1'b0};
    else if (ex_is_jal) redirect_pc_d = br_target;
    else if (taken_d)   redirect_pc_d = br_target;
  end

  assign bht_we  = accept && cond_branch;
  assign upd_idx = ex_pc[IDX+1:2];
  assign bht_cur = bht_q[upd_idx];

  always_comb begin
    bht_d = bht_cur;
    if (taken_d) begin
      if (bht_cur != 2'b11) bht_d = bht_cur + 2'd1;
    end else begin
      if (bht_cur != 2'b00) bht_d = bht_cur - 2'd1;
    end
  end

  // Fetch sees the pre-update value on a same-cycle index collision.
  assign if_pred_taken = bht_q[if_pc[IDX+1:2]][1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (bht_we) begin
      bht_q[upd_idx] <= bht_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      flush_cnt_q        <= '0;
      redirect_q         <= 1'b0;
      redirect_pc_q      <= '0;
      flush_q            <= 1'b0;
      mispredict_count_q <= '0;
    end else begin
      redirect_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (redirect_d) begin
            state_q       <= FLUSH;
            redirect_q    <= 1'b1;
            redirect_pc_q <= redirect_pc_d;
            flush_q       <= 1'b1;
            flush_cnt_q   <= CW'(FLUSH_CYCLES - 1);
            if (mispredict_d && (mispredict_count_q != 16'hFFFF))
              mispredict_count_q <= mispredict_count_q + 16'd1;
          end
        end
        FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign redirect         = redirect_q;
  assign redirect_pc      = redirect_pc_q;
  assign flush            = flush_q;
  assign mispredict_count = mispredict_count_q;

  assign unused_ok = ^{if_pc[31:IDX+2], if_pc[1:0], jalr_sum[0]};

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed scenarios plus random traffic
// against a window-based behavioural model of redirect, flush and the BHT.
module tb_branch_resolve;
  localparam int N  = 16;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        ex_is_branch = 1'b0;
  logic        ex_is_jal = 1'b0;
  logic        ex_is_jalr = 1'b0;
  logic [31:0] ex_imm = '0;
  logic [31:0] ex_rs1 = '0;
  logic        ex_pred_taken = 1'b0;
  logic        br_eq = 1'b0;
  logic        br_l = 1'b0;
  logic        br_un;
  logic [31:0] if_pc = '0;
  logic        if_pred_taken;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] mispredict_count;

  always #5 clk = ~clk;

  branch_resolve #(.BHT_ENTRIES(N), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_funct3(ex_funct3), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_pred_taken(ex_pred_taken), .br_eq(br_eq), .br_l(br_l), .br_un(br_un),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush(flush), .mispredict_count(mispredict_count)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // Reference state: counters, stat count, and how many more edges ignore EX.
  int m_bht[N];
  int m_cnt = 0;
  int m_ignore = 0;
  bit m_exp_redir = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit spec_taken(input logic [2:0] f3, input logic eq, input logic lt);
    bit base;
    base = f3[2] ? lt : eq;
    return base ^ f3[0];
  endfunction

  task automatic expect_redirect(input logic [31:0] tgt);
    exp_q.push_back(tgt);
    m_exp_redir = 1'b1;
    m_ignore = FC;
  endtask

  task automatic model_edge();
    logic [31:0] t;
    int idx;
    bit tk;
    m_exp_redir = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_bht[i] = 1;
      m_cnt = 0;
      m_ignore = 0;
      exp_q.delete();
      return;
    end
    if (m_ignore > 0) begin
      m_ignore--;
      return;
    end
    if (!ex_valid) return;
    if (ex_is_jalr) begin
      t = ex_rs1 + ex_imm;
      t[0] = 1'b0;
      expect_redirect(t);
    end else if (ex_is_jal) begin
      expect_redirect(ex_pc + ex_imm);
    end else if (ex_is_branch && (ex_funct3[2:1] != 2'b01)) begin
      tk = spec_taken(ex_funct3, br_eq, br_l);
      idx = int'(ex_pc[5:2]);
      if (tk) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
      else    m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
      if (tk != ex_pred_taken) begin
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        expect_redirect(tk ? ex_pc + ex_imm : ex_pc + 32'd4);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("redirect", {31'b0, redirect}, {31'b0, m_exp_redir});
    chk("flush", {31'b0, flush}, (m_ignore > 0) ? 32'd1 : 32'd0);
    chk("mispredict_count", {16'b0, mispredict_count}, 32'(m_cnt));
    chk("if_pred_taken", {31'b0, if_pred_taken}, (m_bht[int'(if_pc[5:2])] >= 2) ? 32'd1 : 32'd0);
    chk("br_un", {31'b0, br_un}, {31'b0, ex_funct3[1]});
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
  endtask

  task automatic issue(input bit br, input bit jal, input bit jalr, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                       input bit pred, input bit eq, input bit lt);
    ex_valid = 1'b1; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_funct3 = f3; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1;
    ex_pred_taken = pred; br_eq = eq; br_l = lt;
    cycle();
  endtask

  // Monitor: every redirect strobe consumes one expected target.
  always @(negedge clk) begin
    if (redirect === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL redirect_unexpected: got pc %h expected no redirect (t=%0t)", redirect_pc, $time);
      end else begin
        chk("redirect_pc", redirect_pc, exp_q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) m_bht[i] = 1;

    // Reset held while fetch sweeps every BHT index.
    rst_n = 1'b0;
    idle();
    for (int a = 0; a < N; a++) begin
      if_pc = 32'(a * 4);
      cycle();
    end
    chk("reset_redirect_pc", redirect_pc, 32'h0);
    rst_n = 1'b1;
    cycle();

    // BEQ taken, predicted not-taken.
    if_pc = 32'h0;
    issue(1, 0, 0, 3'b000, 32'h100, 32'h20, 32'h0, 0, 1, 0);
    idle();
    repeat (3) cycle();
    chk("beq_count", {16'b0, mispredict_count}, 32'd1);
    if_pc = 32'h100;
    cycle();
    chk("beq_bht_pred", {31'b0, if_pred_taken}, 32'd1);

    // BLTU not taken, predicted taken -> fall-through.
    issue(1, 0, 0, 3'b110, 32'h200, 32'h40, 32'h0, 1, 0, 0);
    idle();
    repeat (3) cycle();
    chk("bltu_count", {16'b0, mispredict_count}, 32'd2);

    // BNE correctly predicted not-taken twice: counter saturates at 00.
    if_pc = 32'h104;
    issue(1, 0, 0, 3'b001, 32'h104, 32'h8, 32'h0, 0, 1, 0);
    issue(1, 0, 0, 3'b001, 32'h104, 32'h8, 32'h0, 0, 1, 0);
    idle();
    cycle();
    // One taken BNE lifts it only to 01, so prediction stays not-taken.
    issue(1, 0, 0, 3'b001, 32'h104, 32'h8, 32'h0, 1, 0, 0);
    idle();
    cycle();
    chk("bne_saturate_pred", {31'b0, if_pred_taken}, 32'd0);

    // JALR, then a mispredicting BEQ during both flush cycles.
    issue(0, 0, 1, 3'b000, 32'h300, 32'h4, 32'h1003, 0, 0, 0);
    issue(1, 0, 0, 3'b000, 32'h180, 32'h10, 32'h0, 0, 1, 0);
    issue(1, 0, 0, 3'b000, 32'h180, 32'h10, 32'h0, 0, 1, 0);
    idle();
    repeat (2) cycle();
    chk("jalr_count_unchanged", {16'b0, mispredict_count}, 32'd2);

    // Random traffic, including illegal funct3 and multiple type flags.
    for (int n = 0; n < 1500; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      ex_valid      = ($urandom_range(0, 4) != 0);
      ex_is_branch  = (kind <= 5) || (kind == 8);
      ex_is_jal     = (kind == 6) || (kind == 8 && $urandom_range(0, 1) == 1);
      ex_is_jalr    = (kind == 7) || (kind == 8 && $urandom_range(0, 1) == 1);
      ex_funct3     = 3'($urandom_range(0, 7));
      ex_pc         = 32'h1000 + 32'($urandom_range(0, 63) * 4);
      ex_imm        = $urandom;
      ex_rs1        = $urandom;
      br_eq         = 1'($urandom_range(0, 1));
      br_l          = 1'($urandom_range(0, 1));
      ex_pred_taken = ($urandom_range(0, 1) == 1) ? (m_bht[int'(ex_pc[5:2])] >= 2)
                                                  : 1'($urandom_range(0, 1));
      if_pc         = $urandom;
      cycle();
    end
    idle();
    repeat (3) cycle();

    // Reset asserted on the first flush cycle aborts the flush.
    issue(1, 0, 0, 3'b000, 32'h140, 32'h10, 32'h0, 0, 1, 0);
    idle();
    rst_n = 1'b0;
    cycle();
    chk("rst_mid_flush", {31'b0, flush}, 32'd0);
    rst_n = 1'b1;
    for (int a = 0; a < N; a++) begin
      if_pc = 32'(a * 4);
      cycle();
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
